// File: rtl/um_pktout_gmii_tx.sv
// Port-side consumer of a UM pktout stream: buffers packets and per-packet flags,
// strips metadata beats and serialises good packets onto an 8-bit GMII transmitter.
module um_pktout_gmii_tx #(
  parameter int DATA_DEPTH = 256,
  parameter int PKT_DEPTH  = 16,
  parameter int MD_BEATS   = 2,   // 1..7: metadata pops must fit before the last preamble cycle
  parameter int IFG_CYCLES = 12   // >= 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in_data,
  input  logic         in_data_wr,
  input  logic         in_valid,
  input  logic         in_valid_wr,
  output logic [7:0]   out_usedw,
  output logic [7:0]   gmii_txd,
  output logic         gmii_tx_en,
  output logic [31:0]  tx_pkt_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  ovf_cnt
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int PAW = $clog2(PKT_DEPTH);
  localparam logic [DAW:0] DATA_FULL = (DAW+1)'(DATA_DEPTH);
  localparam logic [PAW:0] PKT_FULL  = (PAW+1)'(PKT_DEPTH);
  localparam logic [2:0]   MD_CNT    = 3'(MD_BEATS);
  localparam logic [7:0]   IFG_LOAD  = 8'(IFG_CYCLES - 2);
  localparam logic [1:0]   TYPE_HEAD = 2'b01;
  localparam logic [1:0]   TYPE_TAIL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SEND = 3'd2,
    ST_IFG  = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  function automatic logic [3:0] last_idx(input logic [1:0] t, input logic [3:0] inv);
    return (t == TYPE_TAIL) ? (4'd15 - inv) : 4'd15;
  endfunction

  function automatic logic [7:0] beat_byte(input logic [127:0] d, input logic [3:0] i);
    return d[{~i, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] sat_usedw(input logic [DAW:0] c);
    if (32'(c) > 32'd255) return 8'hFF;
    else return 8'(c);
  endfunction

  // data FIFO
  logic [133:0]   data_mem_r [DATA_DEPTH];
  logic [DAW-1:0] data_wptr_r, data_rptr_r;
  logic [DAW:0]   data_cnt_r, data_cnt_next_s;
  logic           data_full_s, data_empty_s, data_push_s, data_pop_s;
  logic [133:0]   head_s;

  // valid-flag FIFO
  logic           valid_mem_r [PKT_DEPTH];
  logic [PAW-1:0] valid_wptr_r, valid_rptr_r;
  logic [PAW:0]   valid_cnt_r;
  logic           valid_full_s, valid_empty_s, valid_push_s, valid_pop_s, valid_head_s;

  // FSM
  state_t         state_r;
  logic [2:0]     pre_cnt_r;
  logic [127:0]   beat_data_r;
  logic           beat_tail_r;
  logic [3:0]     idx_r, last_r;
  logic [7:0]     ifg_cnt_r;
  logic           md_slot_s, malformed_s, head_is_tail_s;

  assign data_full_s   = (data_cnt_r == DATA_FULL);
  assign data_empty_s  = (data_cnt_r == {(DAW+1){1'b0}});
  assign data_push_s   = in_data_wr && !data_full_s;
  assign head_s        = data_mem_r[data_rptr_r];
  assign head_is_tail_s = (head_s[133:132] == TYPE_TAIL);

  assign valid_full_s  = (valid_cnt_r == PKT_FULL);
  assign valid_empty_s = (valid_cnt_r == {(PAW+1){1'b0}});
  assign valid_push_s  = in_valid_wr && !valid_full_s;
  assign valid_head_s  = valid_mem_r[valid_rptr_r];

  assign md_slot_s   = (state_r == ST_PRE) && (pre_cnt_r < MD_CNT);
  assign malformed_s = md_slot_s && (data_empty_s || head_is_tail_s ||
                       ((pre_cnt_r == 3'd0) && (head_s[133:132] != TYPE_HEAD)));

  // Pop decisions follow the FSM so the show-ahead head is consumed exactly when used.
  always_comb begin
    data_pop_s  = 1'b0;
    valid_pop_s = (state_r == ST_IDLE) && !valid_empty_s;
    case (state_r)
      ST_PRE:  data_pop_s = (md_slot_s || (pre_cnt_r == 3'd7)) && !data_empty_s;
      ST_SEND: data_pop_s = (idx_r == last_r) && !beat_tail_r && !data_empty_s;
      ST_DROP: data_pop_s = !data_empty_s;
      default: data_pop_s = 1'b0;
    endcase
  end

  // Next data occupancy; feeds both the count and the registered usedw.
  always_comb begin
    data_cnt_next_s = data_cnt_r;
    case ({data_push_s, data_pop_s})
      2'b10:   data_cnt_next_s = data_cnt_r + (DAW+1)'(1);
      2'b01:   data_cnt_next_s = data_cnt_r - (DAW+1)'(1);
      default: data_cnt_next_s = data_cnt_r;
    endcase
  end

  // FIFO storage carries no reset; only pointers and counts define contents.
  always_ff @(posedge clk) begin
    if (data_push_s) data_mem_r[data_wptr_r] <= in_data;
    if (valid_push_s) valid_mem_r[valid_wptr_r] <= in_valid;
  end

  // FIFO pointers, occupancy and the overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_wptr_r  <= {DAW{1'b0}};
      data_rptr_r  <= {DAW{1'b0}};
      data_cnt_r   <= {(DAW+1){1'b0}};
      out_usedw    <= 8'h00;
      valid_wptr_r <= {PAW{1'b0}};
      valid_rptr_r <= {PAW{1'b0}};
      valid_cnt_r  <= {(PAW+1){1'b0}};
      ovf_cnt      <= 32'd0;
    end else begin
      if (data_push_s) data_wptr_r <= data_wptr_r + DAW'(1);
      if (data_pop_s)  data_rptr_r <= data_rptr_r + DAW'(1);
      data_cnt_r <= data_cnt_next_s;
      out_usedw  <= sat_usedw(data_cnt_next_s);
      if (valid_push_s) valid_wptr_r <= valid_wptr_r + PAW'(1);
      if (valid_pop_s)  valid_rptr_r <= valid_rptr_r + PAW'(1);
      case ({valid_push_s, valid_pop_s})
        2'b10:   valid_cnt_r <= valid_cnt_r + (PAW+1)'(1);
        2'b01:   valid_cnt_r <= valid_cnt_r - (PAW+1)'(1);
        default: valid_cnt_r <= valid_cnt_r;
      endcase
      ovf_cnt <= ovf_cnt + 32'(in_data_wr && data_full_s) + 32'(in_valid_wr && valid_full_s);
    end
  end

  // Transmit FSM with registered GMII outputs and packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pre_cnt_r   <= 3'd0;
      beat_data_r <= 128'd0;
      beat_tail_r <= 1'b0;
      idx_r       <= 4'd0;
      last_r      <= 4'd0;
      ifg_cnt_r   <= 8'd0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= 8'h00;
      tx_pkt_cnt  <= 32'd0;
      drop_cnt    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (!valid_empty_s) begin
            if (valid_head_s) begin
              state_r    <= ST_PRE;
              pre_cnt_r  <= 3'd0;
              gmii_tx_en <= 1'b1;
              gmii_txd   <= 8'h55;
            end else begin
              state_r <= ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (malformed_s) begin
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            // The offending beat may already be the tail; otherwise drain the remainder.
            if (data_empty_s || head_is_tail_s) begin
              drop_cnt <= drop_cnt + 32'd1;
              state_r  <= ST_IDLE;
            end else begin
              state_r <= ST_DROP;
            end
          end else if (pre_cnt_r == 3'd7) begin
            if (data_empty_s) begin
              gmii_tx_en <= 1'b0;
              gmii_txd   <= 8'h00;
              drop_cnt   <= drop_cnt + 32'd1;
              state_r    <= ST_IDLE;
            end else begin
              beat_data_r <= head_s[127:0];
              beat_tail_r <= head_is_tail_s;
              idx_r       <= 4'd0;
              last_r      <= last_idx(head_s[133:132], head_s[131:128]);
              gmii_txd    <= head_s[127:120];
              state_r     <= ST_SEND;
            end
          end else begin
            pre_cnt_r <= pre_cnt_r + 3'd1;
            gmii_txd  <= (pre_cnt_r == 3'd6) ? 8'hD5 : 8'h55;
          end
        end
        ST_SEND: begin
          if (idx_r == last_r) begin
            if (beat_tail_r) begin
              gmii_tx_en <= 1'b0;
              gmii_txd   <= 8'h00;
              tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
              ifg_cnt_r  <= IFG_LOAD;
              state_r    <= ST_IFG;
            end else if (data_empty_s) begin
              gmii_tx_en <= 1'b0;
              gmii_txd   <= 8'h00;
              drop_cnt   <= drop_cnt + 32'd1;
              state_r    <= ST_IDLE;
            end else begin
              beat_data_r <= head_s[127:0];
              beat_tail_r <= head_is_tail_s;
              idx_r       <= 4'd0;
              last_r      <= last_idx(head_s[133:132], head_s[131:128]);
              gmii_txd    <= head_s[127:120];
            end
          end else begin
            idx_r    <= idx_r + 4'd1;
            gmii_txd <= beat_byte(beat_data_r, idx_r + 4'd1);
          end
        end
        ST_IFG: begin
          // The IDLE cycle that pops the next flag is the last gap cycle.
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (ifg_cnt_r == 8'd0) state_r <= ST_IDLE;
          else ifg_cnt_r <= ifg_cnt_r - 8'd1;
        end
        ST_DROP: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (data_empty_s || head_is_tail_s) begin
            drop_cnt <= drop_cnt + 32'd1;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/um_pktout_gmii_tx.md
Name: um_pktout_gmii_tx

Overview:
- Port-side consumer of one UM output stream (`pktout_data_x`, `pktout_data_wr_x`, `pktout_valid_x`, `pktout_valid_wr_x`). It is the receiving end of the pktout interface and the source of the `pktout_usedw_x` backpressure count.
- Buffers whole packets in a data FIFO and a per-packet valid-flag FIFO, strips the leading metadata beats, and serialises good packets onto an 8-bit GMII transmit interface.
- Bad packets (valid=0) are discarded without transmission.

Parameters:
- DATA_DEPTH, 256, data FIFO depth in 134-bit beats (power of 2).
- PKT_DEPTH, 16, valid-flag FIFO depth in packets.
- MD_BEATS, 2, metadata beats at the head of each packet, read but not transmitted.
- IFG_CYCLES, 12, idle cycles after each transmitted frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  134  beat: [133:132] 01 head / 11 middle / 10 tail; [131:128] invalid byte count (tail only); [127:0] bytes, [127:120] first
- in_data_wr  in  1  beat write strobe
- in_valid  in  1  packet good flag
- in_valid_wr  in  1  valid strobe, coincident with or after the tail beat
- out_usedw  out  8  data FIFO occupancy, saturates at 255
- gmii_txd  out  8  transmit byte
- gmii_tx_en  out  1  transmit enable
- tx_pkt_cnt  out  32  frames transmitted
- drop_cnt  out  32  packets discarded (valid=0 or malformed)
- ovf_cnt  out  32  beats or valid flags lost to a full FIFO

Behaviour:
- Reset (synchronous, active-high): both FIFOs are emptied, the FSM goes to IDLE, and all outputs are 0 (`gmii_txd`=0x00, `gmii_tx_en`=0, all counters 0). Reset mid-frame truncates the frame immediately.
- Write side:
  - `in_data_wr` pushes `in_data` unless the data FIFO is full; if full the beat is dropped and `ovf_cnt`++.
  - `in_valid_wr` pushes `in_valid` unless the valid FIFO is full; if full, `ovf_cnt`++.
  - A simultaneous push and pop leaves occupancy unchanged.
  - `out_usedw` is registered and reflects occupancy after the previous cycle's push/pop.
- Both FIFOs are show-ahead.
- A packet is eligible once its valid flag is present. Flags arrive after the tail beat, so the whole packet is resident before transmission starts; no underrun is possible.
- FSM states:
  - IDLE: if the valid FIFO is non-empty, pop the flag. Flag=1 goes to PRE; flag=0 goes to DROP.
  - PRE: 8 cycles, `gmii_tx_en`=1, `gmii_txd`=0x55 ×7 then 0xD5. The first preamble byte appears the cycle after the IDLE pop. During PRE, pop MD_BEATS beats. If any of those is a tail, or the first beat is not a head, the frame is malformed: it is aborted as in DROP.
  - SEND:
    - Latch one beat and emit bytes [127:120] down to [7:0], one per cycle.
    - Pop the next beat on the cycle the last byte of the current beat is emitted, so there is no gap between beats.
    - On a tail beat, emit 16 − `in_data[131:128]` bytes, then `tx_pkt_cnt`++ and go to IFG.
    - A tail with invalid count ≥16 emits 0 bytes from that beat.
    - The block appends no FCS; upstream data includes it.
  - IFG: `gmii_tx_en`=0 for IFG_CYCLES cycles, then IDLE.
  - DROP: pop beats one per cycle through the tail; `drop_cnt`++; then IDLE. `gmii_tx_en` stays 0.
- Abort path: if PRE detects a malformed packet, `gmii_tx_en` deasserts immediately, the rest of the packet is drained as in DROP, and `drop_cnt`++ with no IFG.
- `gmii_txd`=0x00 whenever `gmii_tx_en`=0.
- Counters wrap at 2^32.

Test Plan:
- Reset mid-SEND of a 4-beat packet → next cycle `gmii_tx_en`=0, `out_usedw`=0, all counters 0.
- One good packet (2 metadata beats + 4 data beats, tail invalid=6, `in_valid`=1) → 8 preamble bytes, then 58 data bytes in order with no gaps; `tx_pkt_cnt`=1; `out_usedw` returns to 0; 12 idle cycles follow.
- Packet with `in_valid`=0 of 5 beats → `gmii_tx_en` never asserts; `drop_cnt`=1; FIFO drains in 5 cycles.
- Back-to-back good packets of 3 data beats each → frames separated by exactly 12 idle cycles; `tx_pkt_cnt`=2.
- Write 260 beats with no valid flag → `out_usedw`=255; `ovf_cnt`=4; the 4 extra beats are not stored.
- Malformed packet (tail in the second metadata beat) → `gmii_tx_en` drops during preamble; `drop_cnt`=1; the following good packet transmits correctly.
